// File: rtl/adc_pkg.sv
// Shared types and constants for the triggered ADC capture controller.
// The optional test-pattern source is enabled by ADC_CAPTURE_TEST_PATTERN_EN (see adc_capture_ctrl).
package adc_pkg;

  typedef enum logic [2:0] {
    IDLE,
    ARM,
    WAIT_TRIG,
    CAPTURE,
    DONE
  } adc_state_t;

  localparam logic [1:0] TRIG_IMM  = 2'd0;
  localparam logic [1:0] TRIG_RISE = 2'd1;
  localparam logic [1:0] TRIG_FALL = 2'd2;

  localparam int ARM_TICKS = 2;

  // Unsigned level-crossing test; the reserved mode behaves like immediate.
  function automatic logic trig_hit(input logic [1:0] mode, input logic [7:0] prev,
                                    input logic [7:0] cur, input logic [7:0] lvl);
    case (mode)
      TRIG_RISE: trig_hit = (prev < lvl) && (cur >= lvl);
      TRIG_FALL: trig_hit = (prev >= lvl) && (cur < lvl);
      default:   trig_hit = 1'b1;
    endcase
  endfunction

endpackage

// File: rtl/adc_sample_fifo.sv
// Synchronous sample FIFO with a registered head entry; capacity is exactly DEPTH entries.
module adc_sample_fifo #(
  parameter int DEPTH = 4,
  parameter int W     = 9
) (
  input  logic         Clk,
  input  logic         Reset_n,
  input  logic         flush_i,
  input  logic         push_i,
  input  logic [W-1:0] din_i,
  input  logic         pop_i,
  output logic [W-1:0] dout_o,
  output logic         valid_o,
  output logic         full_o,
  output logic         empty_o
);

  localparam int          AW       = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  logic [W-1:0]  mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, rd_ptr_q, rd_ptr_d;
  logic [AW:0]   cnt_q, cnt_pop, cnt_d;
  logic [W-1:0]  dout_q, dout_d;
  logic          valid_q, do_push, do_pop;

  assign full_o  = (cnt_q == FULL_CNT);
  assign empty_o = (cnt_q == '0);
  assign do_pop  = pop_i && !empty_o;
  assign do_push = push_i && (!full_o || do_pop);
  assign dout_o  = dout_q;
  assign valid_o = valid_q;

  // The head register mirrors the entry that will be at rd_ptr after this edge.
  always_comb begin
    rd_ptr_d = rd_ptr_q + AW'(do_pop);
    cnt_pop  = cnt_q - (AW+1)'(do_pop);
    cnt_d    = cnt_pop + (AW+1)'(do_push);
    dout_d   = (cnt_pop == '0) ? din_i : mem_q[rd_ptr_d];
  end

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
      valid_q  <= 1'b0;
      dout_q   <= '0;
    end else if (flush_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
      valid_q  <= 1'b0;
      dout_q   <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + AW'(1);
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
      valid_q  <= (cnt_d != '0);
      dout_q   <= dout_d;
    end
  end

  always_ff @(posedge Clk) begin
    if (do_push && !flush_i) mem_q[wr_ptr_q] <= din_i;
  end

endmodule

// File: rtl/adc_capture_ctrl.sv
// Triggered fixed-length capture controller for a parallel 8-bit ADC.
// Define ADC_CAPTURE_TEST_PATTERN_EN to add the TestMode input and internal ramp source.
//
// state     | meaning
// IDLE      | ADC output disabled, waiting for Start
// ARM       | output enabled, discarding ARM_TICKS settle samples
// WAIT_TRIG | watching samples for the trigger condition
// CAPTURE   | pushing one sample per tick until the length counter expires
// DONE      | one-cycle completion pulse
module adc_capture_ctrl
  import adc_pkg::*;
#(
  parameter int CLK_DIV    = 9,
  parameter int LEN_W      = 10,
  parameter int FIFO_DEPTH = 4
) (
  input  logic             Clk,
  input  logic             Reset_n,
  input  logic [7:0]       Data,
  output logic             nOE,
  output logic             AdcClk,
  input  logic             Start,
  input  logic             Abort,
`ifdef ADC_CAPTURE_TEST_PATTERN_EN
  input  logic             TestMode,
`endif
  input  logic [1:0]       TrigMode,
  input  logic [7:0]       TrigLevel,
  input  logic [LEN_W-1:0] CaptureLen,
  output logic [7:0]       SampleData,
  output logic             SampleValid,
  input  logic             SampleReady,
  output logic             SampleLast,
  output logic             Busy,
  output logic             Done,
  output logic             Overflow
);

  localparam int DIV_W = (CLK_DIV < 1) ? 1 : $clog2(CLK_DIV + 1);

  adc_state_t       state_q;
  logic [DIV_W-1:0] div_q;
  logic             adc_clk_q, tick, tick_d1_q;
  logic [7:0]       sample_q, sample_src, prev_q;
  logic [LEN_W-1:0] cnt_q;
  logic [1:0]       arm_q;
  logic             first_q, busy_q, noe_q, done_q, overflow_q;
  logic             push_q;
  logic [8:0]       push_data_q;
  logic             fire, capture_now, last_now, ovf_set;
  logic             fifo_full, fifo_empty, fifo_pop;
  logic [8:0]       fifo_dout;

  // A tick is the Clk edge on which AdcClk rises and the sample register loads.
  assign tick = (div_q == DIV_W'(CLK_DIV)) && !adc_clk_q;

`ifdef ADC_CAPTURE_TEST_PATTERN_EN
  logic [7:0] ramp_q;

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n)  ramp_q <= '0;
    else if (Start) ramp_q <= '0;
    else if (tick)  ramp_q <= ramp_q + 8'd1;
  end

  assign sample_src = TestMode ? ramp_q : Data;
`else
  assign sample_src = Data;
`endif

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      div_q     <= '0;
      adc_clk_q <= 1'b1;
      tick_d1_q <= 1'b0;
      sample_q  <= '0;
    end else begin
      tick_d1_q <= tick;
      if (div_q == DIV_W'(CLK_DIV)) begin
        div_q     <= '0;
        adc_clk_q <= ~adc_clk_q;
      end else begin
        div_q <= div_q + DIV_W'(1);
      end
      if (tick) sample_q <= sample_src;
    end
  end

  // Edge modes need one sample of history before they may fire.
  assign fire = trig_hit(TrigMode, prev_q, sample_q, TrigLevel) &&
                !(first_q && (TrigMode == TRIG_RISE || TrigMode == TRIG_FALL));
  assign capture_now = tick_d1_q && ((state_q == CAPTURE) || (state_q == WAIT_TRIG && fire));
  assign last_now    = (cnt_q == LEN_W'(1));
  assign fifo_pop    = SampleReady && !fifo_empty;
  assign ovf_set     = push_q && fifo_full && !fifo_pop && !Abort;

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      arm_q       <= '0;
      prev_q      <= '0;
      first_q     <= 1'b0;
      busy_q      <= 1'b0;
      noe_q       <= 1'b1;
      done_q      <= 1'b0;
      overflow_q  <= 1'b0;
      push_q      <= 1'b0;
      push_data_q <= '0;
    end else begin
      push_q <= 1'b0;
      done_q <= 1'b0;
      if (ovf_set) overflow_q <= 1'b1;
      if (Abort) begin
        state_q <= IDLE;
        busy_q  <= 1'b0;
        noe_q   <= 1'b1;
      end else begin
        case (state_q)
          IDLE: begin
            if (Start && CaptureLen != '0) begin
              state_q    <= ARM;
              busy_q     <= 1'b1;
              noe_q      <= 1'b0;
              cnt_q      <= CaptureLen;
              prev_q     <= sample_q;
              arm_q      <= '0;
              overflow_q <= 1'b0;
            end
          end
          ARM: begin
            if (tick_d1_q) begin
              if (arm_q == 2'(ARM_TICKS - 1)) begin
                state_q <= WAIT_TRIG;
                first_q <= 1'b1;
              end else begin
                arm_q <= arm_q + 2'd1;
              end
            end
          end
          WAIT_TRIG, CAPTURE: begin
            if (tick_d1_q) begin
              prev_q  <= sample_q;
              first_q <= 1'b0;
              if (capture_now) begin
                push_q      <= 1'b1;
                push_data_q <= {last_now, sample_q};
                cnt_q       <= cnt_q - LEN_W'(1);
                if (last_now) begin
                  state_q <= DONE;
                  done_q  <= 1'b1;
                end else begin
                  state_q <= CAPTURE;
                end
              end
            end
          end
          DONE: begin
            state_q <= IDLE;
            busy_q  <= 1'b0;
            noe_q   <= 1'b1;
          end
          default: state_q <= IDLE;
        endcase
      end
    end
  end

  adc_sample_fifo #(
    .DEPTH (FIFO_DEPTH),
    .W     (9)
  ) u_fifo (
    .Clk     (Clk),
    .Reset_n (Reset_n),
    .flush_i (Abort),
    .push_i  (push_q),
    .din_i   (push_data_q),
    .pop_i   (fifo_pop),
    .dout_o  (fifo_dout),
    .valid_o (SampleValid),
    .full_o  (fifo_full),
    .empty_o (fifo_empty)
  );

  assign SampleData = fifo_dout[7:0];
  assign SampleLast = fifo_dout[8];
  assign nOE        = noe_q;
  assign AdcClk     = adc_clk_q;
  assign Busy       = busy_q;
  assign Done       = done_q;
  assign Overflow   = overflow_q;

endmodule

// File: tb/tb_adc_capture_ctrl.sv
// Self-checking bench for adc_capture_ctrl: vector table plus hand-written corner sequences.
module tb_adc_capture_ctrl;

  localparam int LEN_W = 10;

  typedef struct packed {
    logic [1:0]       mode;
    logic [7:0]       lvl;
    logic [LEN_W-1:0] len;
    logic [0:7][7:0]  seq;   // samples seen in WAIT_TRIG, in order
    logic [2:0]       nexp;
    logic [0:3][7:0]  exp;   // captured samples, Last on entry nexp-1
  } vec_t;

  logic             Clk = 1'b0, Reset_n = 1'b0, Start = 1'b0, Abort = 1'b0, SampleReady = 1'b0;
  logic [7:0]       Data = 8'd0, TrigLevel = 8'd0;
  logic [1:0]       TrigMode = 2'd0;
  logic [LEN_W-1:0] CaptureLen = '0;
  logic             nOE, AdcClk, SampleValid, SampleLast, Busy, Done, Overflow;
  logic [7:0]       SampleData;

  int         n_vec = 0, n_err = 0, done_cnt = 0;
  logic [8:0] exp_q[$];
  logic [7:0] drv_q[$];
  logic [7:0] seq_q[$];
  bit         rand_rdy = 1'b0;
  bit         stall = 1'b0;
  logic [8:0] stall_val = '0;
  vec_t       tbl [9];

  adc_capture_ctrl #(.CLK_DIV(9), .LEN_W(LEN_W), .FIFO_DEPTH(4)) dut (
    .Clk         (Clk),
    .Reset_n     (Reset_n),
    .Data        (Data),
    .nOE         (nOE),
    .AdcClk      (AdcClk),
    .Start       (Start),
    .Abort       (Abort),
`ifdef ADC_CAPTURE_TEST_PATTERN_EN
    .TestMode    (1'b0),
`endif
    .TrigMode    (TrigMode),
    .TrigLevel   (TrigLevel),
    .CaptureLen  (CaptureLen),
    .SampleData  (SampleData),
    .SampleValid (SampleValid),
    .SampleReady (SampleReady),
    .SampleLast  (SampleLast),
    .Busy        (Busy),
    .Done        (Done),
    .Overflow    (Overflow)
  );

  always #5 Clk = ~Clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_vec++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, req);
    end
  endtask

  // Scoreboard consumer and stall-stability monitor.
  initial forever begin
    @(negedge Clk);
    if (Reset_n) begin
      if (stall) check("stall_hold", {23'd0, SampleValid, SampleLast, SampleData}, {23'd0, 1'b1, stall_val});
      if (SampleValid && SampleReady) begin
        if (exp_q.size() == 0) begin
          n_vec++;
          n_err++;
          $display("FAIL unexpected_sample: got 0x%0h, expected none", {SampleLast, SampleData});
        end else begin
          check("sample", {23'd0, SampleLast, SampleData}, {23'd0, exp_q.pop_front()});
        end
      end
      stall     = SampleValid && !SampleReady;
      stall_val = {SampleLast, SampleData};
      if (Done) done_cnt++;
    end
  end

  // Supplies the value sampled at each following tick.
  initial forever begin
    @(posedge AdcClk);
    #1;
    if (drv_q.size() > 0) Data = drv_q.pop_front();
  end

  initial forever begin
    @(posedge Clk);
    #1;
    if (rand_rdy) SampleReady = 1'($urandom_range(0, 1));
  end

  initial begin
    #900000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1);
  end

  task automatic set_ready(input logic v);
    @(posedge Clk);
    #1;
    SampleReady = v;
  endtask

  // Two ARM-discarded samples precede seq_q.
  task automatic start_capture(input logic [1:0] m, input logic [7:0] l, input logic [LEN_W-1:0] n);
    @(posedge AdcClk);
    #2;
    TrigMode   = m;
    TrigLevel  = l;
    CaptureLen = n;
    Data       = 8'hAA;
    drv_q.delete();
    drv_q.push_back(8'hA5);
    foreach (seq_q[j]) drv_q.push_back(seq_q[j]);
    Start = 1'b1;
    @(posedge Clk);
    #1;
    Start = 1'b0;
    @(negedge Clk);
    check("noe_after_start", nOE, 0);
    check("busy_after_start", Busy, 1);
    check("ovf_cleared_by_start", Overflow, 0);
  endtask

  task automatic wait_done();
    int k = 0;
    while (Done !== 1'b1 && k < 3000) begin
      @(negedge Clk);
      k++;
    end
    check("done_seen", Done, 1);
    @(negedge Clk);
    check("done_width", Done, 0);
    check("busy_after_done", Busy, 0);
    check("noe_after_done", nOE, 1);
  endtask

  task automatic drain();
    int k = 0;
    while (exp_q.size() != 0 && k < 4000) begin
      @(negedge Clk);
      k++;
    end
    check("drain_left", exp_q.size(), 0);
    exp_q.delete();
    repeat (40) @(negedge Clk);
    check("valid_after_drain", SampleValid, 0);
  endtask

  task automatic apply_vec(input int i);
    int d0;
    int ne;
    ne = int'(tbl[i].nexp);
    seq_q.delete();
    for (int j = 0; j < 8; j++) seq_q.push_back(tbl[i].seq[j]);
    for (int j = 0; j < ne; j++) exp_q.push_back({j == ne - 1, tbl[i].exp[j]});
    set_ready(1'b1);
    d0 = done_cnt;
    start_capture(tbl[i].mode, tbl[i].lvl, tbl[i].len);
    wait_done();
    drain();
    check("done_count", done_cnt - d0, 1);
    check("no_overflow", Overflow, 0);
  endtask

  initial begin
    int lo, hi, k, d0;

    tbl[0] = '{2'd0, 8'd0,   10'd4, {8'd10, 8'd11, 8'd12, 8'd13, 8'd14, 8'd15, 8'd16, 8'd17}, 3'd4, {8'd10, 8'd11, 8'd12, 8'd13}};
    tbl[1] = '{2'd1, 8'd128, 10'd3, {8'd100, 8'd120, 8'd127, 8'd130, 8'd140, 8'd150, 8'd160, 8'd170}, 3'd3, {8'd130, 8'd140, 8'd150, 8'd0}};
    tbl[2] = '{2'd2, 8'd128, 10'd3, {8'd150, 8'd140, 8'd130, 8'd127, 8'd120, 8'd100, 8'd90, 8'd80}, 3'd3, {8'd127, 8'd120, 8'd100, 8'd0}};
    tbl[3] = '{2'd3, 8'd200, 10'd2, {8'd5, 8'd6, 8'd7, 8'd8, 8'd9, 8'd10, 8'd11, 8'd12}, 3'd2, {8'd5, 8'd6, 8'd0, 8'd0}};
    tbl[4] = '{2'd1, 8'd128, 10'd2, {8'd200, 8'd100, 8'd130, 8'd131, 8'd132, 8'd133, 8'd134, 8'd135}, 3'd2, {8'd130, 8'd131, 8'd0, 8'd0}};
    tbl[5] = '{2'd1, 8'd255, 10'd1, {8'd0, 8'd254, 8'd255, 8'd1, 8'd2, 8'd3, 8'd4, 8'd5}, 3'd1, {8'd255, 8'd0, 8'd0, 8'd0}};
    tbl[6] = '{2'd2, 8'd1,   10'd1, {8'd200, 8'd1, 8'd0, 8'd7, 8'd8, 8'd9, 8'd10, 8'd11}, 3'd1, {8'd0, 8'd0, 8'd0, 8'd0}};
    tbl[7] = '{2'd2, 8'd128, 10'd2, {8'd128, 8'd127, 8'd126, 8'd125, 8'd124, 8'd123, 8'd122, 8'd121}, 3'd2, {8'd127, 8'd126, 8'd0, 8'd0}};
    tbl[8] = '{2'd1, 8'd128, 10'd1, {8'd127, 8'd128, 8'd129, 8'd130, 8'd131, 8'd132, 8'd133, 8'd134}, 3'd1, {8'd128, 8'd0, 8'd0, 8'd0}};

    repeat (3) @(negedge Clk);
    check("rst_noe", nOE, 1);
    check("rst_adcclk", AdcClk, 1);
    check("rst_valid_last", {SampleValid, SampleLast}, 0);
    check("rst_data", SampleData, 0);
    check("rst_busy_done_ovf", {Busy, Done, Overflow}, 0);
    @(posedge Clk);
    #1;
    Reset_n = 1'b1;

    k = 0;
    while (AdcClk !== 1'b0 && k < 100) begin @(negedge Clk); k++; end
    lo = 0;
    while (AdcClk === 1'b0 && lo < 100) begin @(negedge Clk); lo++; end
    hi = 0;
    while (AdcClk === 1'b1 && hi < 100) begin @(negedge Clk); hi++; end
    check("adcclk_low_cycles", lo, 10);
    check("adcclk_high_cycles", hi, 10);
    check("noe_idle", nOE, 1);

    for (int i = 0; i < 9; i++) apply_vec(i);

    // Overflow: Ready held low, only the first FIFO_DEPTH samples survive, Last is dropped.
    seq_q.delete();
    for (int j = 0; j < 8; j++) seq_q.push_back(8'(10 + j));
    for (int j = 0; j < 4; j++) exp_q.push_back({1'b0, 8'(10 + j)});
    set_ready(1'b0);
    d0 = done_cnt;
    start_capture(2'd0, 8'd0, 10'd8);
    wait_done();
    check("overflow_set", Overflow, 1);
    set_ready(1'b1);
    drain();
    check("done_count_ovf", done_cnt - d0, 1);
    check("overflow_sticky", Overflow, 1);
    apply_vec(0);

    // Abort together with Start in the middle of CAPTURE.
    seq_q.delete();
    for (int j = 0; j < 8; j++) seq_q.push_back(8'(30 + j));
    for (int j = 0; j < 8; j++) exp_q.push_back({j == 7, 8'(30 + j)});
    set_ready(1'b1);
    d0 = done_cnt;
    start_capture(2'd0, 8'd0, 10'd8);
    k = 0;
    while (exp_q.size() > 6 && k < 3000) begin @(negedge Clk); k++; end
    check("abort_progress", exp_q.size() <= 6, 1);
    @(posedge Clk);
    #1;
    Abort = 1'b1;
    Start = 1'b1;
    @(posedge Clk);
    #1;
    Abort = 1'b0;
    Start = 1'b0;
    @(negedge Clk);
    check("abort_valid", SampleValid, 0);
    check("abort_noe", nOE, 1);
    check("abort_busy", Busy, 0);
    exp_q.delete();
    repeat (200) @(negedge Clk);
    check("abort_no_done", done_cnt - d0, 0);
    check("abort_stays_idle", {Busy, SampleValid}, 0);
    apply_vec(1);

    // Random backpressure over a 16-sample capture.
    seq_q.delete();
    for (int j = 0; j < 16; j++) seq_q.push_back(8'(50 + j));
    for (int j = 0; j < 16; j++) exp_q.push_back({j == 15, 8'(50 + j)});
    d0 = done_cnt;
    rand_rdy = 1'b1;
    start_capture(2'd0, 8'd0, 10'd16);
    wait_done();
    drain();
    rand_rdy = 1'b0;
    set_ready(1'b1);
    check("done_count_bp", done_cnt - d0, 1);
    check("no_overflow_bp", Overflow, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
